gen_deser_stage: RTL and testbench

Serial-to-parallel deserializer that sits directly upstream of the generate-for inverter array. It assembles WIDTH serial bits into one word and holds that word in a single-entry output register. The word is released to the downstream stage under a valid/ready handshake. The shift chain is one flop per bit, built with a generate-for loop, so the stage scales with WIDTH the same way the inverter array does.

---
 rtl/gen_deser_stage.sv | 86 ++++++++
 tb/tb_gen_deser_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gen_deser_stage.sv
// gen_deser_stage: serial-to-parallel deserializer with a one-entry
// output register released to the inverter array over valid/ready.
module gen_deser_stage #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             done;

    // Shift direction picks which end of the word the first bit lands in.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign sh_nxt = {ser_in, sh[WIDTH-1:1]};
        end else begin : g_msb
            assign sh_nxt = {sh[WIDTH-2:0], ser_in};
        end
    endgenerate

    assign done = ser_valid && (cnt == LAST);

    // Next bit count; wraps to zero on the edge that completes a word.
    always_comb begin
        cnt_nxt = cnt;
        if (ser_valid) begin
            if (cnt == LAST) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // One flop per shift-chain bit so the chain scales with WIDTH.
    for (genvar i = 0; i < WIDTH; i++) begin : g_sh
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sh[i] <= 1'b0;
            end else if (ser_valid) begin
                sh[i] <= sh_nxt[i];
            end
        end
    end

    // Counter, busy flag, output register and overrun pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            busy       <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            busy    <= (cnt_nxt != '0);
            overrun <= 1'b0;
            if (done) begin
                if (!word_valid || word_ready) begin
                    word_out   <= sh_nxt;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gen_deser_stage.sv
// tb_gen_deser_stage: directed bench for both bit orders of the
// deserializer, sharing one serial stream between two instances.
module tb_gen_deser_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_in;
    logic       ser_valid;
    logic       word_ready;
    logic [7:0] word_a, word_b;
    logic       valid_a, valid_b;
    logic       busy_a, busy_b;
    logic       ovr_a, ovr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gen_deser_stage #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
        .word_out(word_a), .word_valid(valid_a), .word_ready(word_ready),
        .busy(busy_a), .overrun(ovr_a)
    );

    gen_deser_stage #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
        .word_out(word_b), .word_valid(valid_b), .word_ready(word_ready),
        .busy(busy_b), .overrun(ovr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends w LSB first; rdy_last >= 0 drives word_ready with the last bit.
    task automatic send_word(input logic [7:0] w, input int gap,
                             input int rdy_last);
        for (int i = 0; i < 8; i++) begin
            ser_in    = w[i];
            ser_valid = 1'b1;
            if (i == 7 && rdy_last >= 0) word_ready = rdy_last[0];
            tick();
            ser_valid = 1'b0;
            if (i < 7) chk("ovr_mid", {31'b0, ovr_a}, 0);
            repeat (gap) tick();
        end
    endtask

    initial begin
        logic [7:0] w;
        rst_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; word_ready = 1'b1;
        tick(); tick();
        chk("rst_word", {24'b0, word_a}, 0);
        chk("rst_valid", {31'b0, valid_a}, 0);
        chk("rst_busy", {31'b0, busy_a}, 0);
        chk("rst_ovr", {31'b0, ovr_a}, 0);
        rst_n = 1'b1;

        // Bits 1,1,0,0,1,1,0,1 back-to-back: B3 LSB first, CD MSB first.
        w = 8'hB3;
        for (int i = 0; i < 8; i++) begin
            ser_in = w[i]; ser_valid = 1'b1;
            tick();
            if (i < 7) begin
                chk("busy_mid", {31'b0, busy_b}, 1);
                chk("early_valid", {31'b0, valid_a}, 0);
            end
        end
        ser_valid = 1'b0;
        chk("busy_end", {31'b0, busy_b}, 0);
        chk("valid_a", {31'b0, valid_a}, 1);
        chk("valid_b", {31'b0, valid_b}, 1);
        chk("word_lsb", {24'b0, word_a}, 32'hB3);
        chk("word_msb", {24'b0, word_b}, 32'hCD);
        chk("inv_out", {24'b0, ~word_a}, 32'h4C);
        tick();
        chk("consume", {31'b0, valid_a}, 0);
        chk("hold_word", {24'b0, word_a}, 32'hB3);

        // Gapped input: three idle cycles after every bit.
        for (int i = 0; i < 8; i++) begin
            ser_in = w[i]; ser_valid = 1'b1;
            tick();
            ser_valid = 1'b0;
            chk("gap_valid", {31'b0, valid_a}, (i == 7) ? 1 : 0);
            if (i < 7) repeat (3) begin
                tick();
                chk("gap_idle", {31'b0, valid_a}, 0);
            end
        end
        chk("gap_word", {24'b0, word_a}, 32'hB3);
        tick();

        // Backpressure: second word dropped with a one-cycle overrun.
        word_ready = 1'b0;
        send_word(8'hB3, 0, -1);
        chk("bp_valid1", {31'b0, valid_a}, 1);
        chk("bp_word1", {24'b0, word_a}, 32'hB3);
        send_word(8'h5A, 0, -1);
        chk("ovr_pulse", {31'b0, ovr_a}, 1);
        chk("bp_word2", {24'b0, word_a}, 32'hB3);
        chk("bp_valid2", {31'b0, valid_a}, 1);
        tick();
        chk("ovr_clear", {31'b0, ovr_a}, 0);
        chk("bp_word3", {24'b0, word_a}, 32'hB3);
        word_ready = 1'b1;
        tick();
        chk("drain_valid", {31'b0, valid_a}, 0);
        chk("no_5a", {24'b0, word_a}, 32'hB3);
        word_ready = 1'b0;

        // Completion and consume on the same edge.
        send_word(8'hB3, 0, -1);
        chk("sim_hold", {24'b0, word_a}, 32'hB3);
        send_word(8'h5A, 0, 1);
        chk("sim_word", {24'b0, word_a}, 32'h5A);
        chk("sim_valid", {31'b0, valid_a}, 1);
        chk("sim_ovr", {31'b0, ovr_a}, 0);
        tick();
        chk("sim_drain", {31'b0, valid_a}, 0);

        // Reset mid-word, with ser_valid held high across the reset edge.
        w = 8'h15;
        for (int i = 0; i < 5; i++) begin
            ser_in = w[i]; ser_valid = 1'b1;
            tick();
        end
        chk("pre_rst_busy", {31'b0, busy_a}, 1);
        rst_n = 1'b0; ser_in = 1'b1;
        tick();
        rst_n = 1'b1; ser_valid = 1'b0;
        chk("mr_word", {24'b0, word_a}, 0);
        chk("mr_valid", {31'b0, valid_a}, 0);
        chk("mr_busy", {31'b0, busy_a}, 0);
        chk("mr_ovr", {31'b0, ovr_a}, 0);
        chk("mr_word_b", {24'b0, word_b}, 0);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            ser_in = w[i]; ser_valid = 1'b1;
            tick();
            if (i < 7) chk("mr_early", {31'b0, valid_a}, 0);
        end
        ser_valid = 1'b0;
        chk("mr_next", {24'b0, word_a}, 32'h3C);
        chk("mr_next_b", {24'b0, word_b}, 32'h3C);
        chk("mr_nvalid", {31'b0, valid_a}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
